reg_file_writeback_stage: RTL
=============================

# reg_file_writeback_stage

Writeback stage of the pd3 MIPS pipeline, downstream of the register-file write-data select logic. It captures a retiring instruction together with its 2-bit write-data select and candidate results. For loads, it waits on the data-memory read handshake. It then drives the single register-file write port. Loads also get byte-lane extraction with sign or zero extension, plus a memory-timeout guard.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- MEM_TIMEOUT, 15, maximum cycles spent in WAIT_MEM before abort

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept
- in_wdata_ctrl  in  2  00 mem word, 01 mem byte, 10 immediate, 11 ALU/link result
- in_reg_we  in  1  instruction writes a register
- in_rd  in  REG_AW  destination register
- in_alu_result  in  DATA_W  ALU or link value
- in_imm  in  DATA_W  pre-shifted immediate
- in_mem_read  in  1  instruction is a load
- in_byte_sel  in  2  address bits [1:0] for byte loads
- in_byte_signed  in  1  sign-extend byte (1) or zero-extend (0)
- mem_rdata  in  DATA_W  data-memory read data
- mem_rdata_valid  in  1  mem_rdata valid this cycle
- flush  in  1  synchronous kill of held and incoming instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- err  out  1  sticky error flag (illegal select or memory timeout)

## Operation
- States: IDLE, WAIT_MEM, WRITE.
- **Acceptance.** A transfer happens when in_valid & in_ready & ~flush at a rising edge. in_ready = (state != WAIT_MEM).
- **Accept to WAIT_MEM or WRITE.**
  - On accept with in_mem_read=1, go to WAIT_MEM and clear the timeout counter.
  - On accept with in_mem_read=0, go to WRITE. rf_wdata is latched from in_imm (ctrl 10) or in_alu_result (ctrl 11).
- **Illegal select.** ctrl 00/01 with in_mem_read=0 is illegal:
  - go to WRITE with the write suppressed (latched reg_we=0);
  - set err.
- **WAIT_MEM.**
  - On mem_rdata_valid, latch the formatted data and go to WRITE.
  - ctrl 00: full word.
  - ctrl 01: big-endian byte lane. sel 0 selects [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0]. The byte is extended per in_byte_signed (latched at accept).
  - ctrl 10/11 with in_mem_read=1: the ALU value is written and mem data is discarded (after valid).
- **Timeout.** The counter increments on every WAIT_MEM cycle without valid. When it reaches MEM_TIMEOUT:
  - set err;
  - drop the instruction (no write);
  - go to IDLE.
- **WRITE.**
  - rf_we = latched reg_we & (rd != 0). rf_waddr and rf_wdata come from the latches.
  - The stage accepts a new instruction in the same cycle. Next state is WAIT_MEM, WRITE, or IDLE (no accept).
- **Outside WRITE.** rf_we=0. rf_waddr/rf_wdata hold their last values.
- **Flush.**
  - Blocks acceptance that cycle.
  - In WRITE, forces rf_we=0.
  - In WAIT_MEM, abandons the load.
  - Next state is IDLE.
  - A mem_rdata_valid arriving in IDLE or WRITE is ignored.
- **err.** Cleared only by reset.

## Timing
- **Reset.** While reset is high: state IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, err=0, timeout counter=0. in_ready=1 only after reset deasserts.
- **Non-load latency.** Accepted at edge E, rf_we is high in the cycle after E. Throughput is one per cycle.
- **Load latency.**
  - Accepted at E.
  - mem_rdata_valid is sampled at edge E+k (k≥1).
  - rf_we is high in the cycle after E+k.
  - in_ready is low from E until the valid edge.
- **mem_rdata_valid in the first WAIT_MEM cycle** gives a load-to-write latency of 2 cycles.
- **Timeout.** With no valid, the abort edge is E+MEM_TIMEOUT. in_ready returns high in the following cycle.
- **Flush and mem_rdata_valid on the same edge in WAIT_MEM.** Flush wins: no write, next state IDLE.
- **Asynchronous reset mid-WAIT_MEM.** The load is discarded immediately and no write occurs.

## Test plan
- **ALU op.** ALU op rd=5, ctrl 11, alu=0x1234_5678 -> next cycle rf_we=1, waddr=5, wdata=0x1234_5678. Back-to-back ops with imm (ctrl 10, 0xABCD_0000) -> writes on consecutive cycles.
- **Byte load, sign-extended.** ctrl 01, sel 1, signed=1, rd=8; mem_rdata=0x11F2_3344 valid 3 cycles later -> wdata=0xFFFF_FFF2 in the cycle after valid. Same with signed=0 -> 0x0000_00F2.
- **Word load, immediate valid.** Word load, valid in the first WAIT_MEM cycle -> write 2 cycles after accept. in_ready low for exactly 1 cycle.
- **Write to r0.** rd=0 with reg_we=1 -> rf_we stays 0.
- **Illegal select.** ctrl 00 with in_mem_read=0 -> no write, err=1 (sticky).
- **Timeout, flush, reset.**
  - Load with no valid for 15 cycles -> err=1, no write, back in IDLE.
  - Flush coincident with valid -> no write.
  - Reset asserted mid-wait -> all outputs 0 at once.

Source files
------------

// File: rtl/reg_file_writeback_stage.sv
// Writeback stage: captures a retiring instruction, waits on data-memory reads for loads,
// formats load data (word or big-endian byte with sign/zero extension) and drives the register-file write port.
module reg_file_writeback_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_wdata_ctrl,
    input  logic              in_reg_we,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_mem_read,
    input  logic [1:0]        in_byte_sel,
    input  logic              in_byte_signed,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

    // Load-side pending fields, held while the read is outstanding.
    logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
    logic                pend_we_q, pend_we_d;
    logic [1:0]          pend_ctrl_q, pend_ctrl_d;
    logic [1:0]          pend_sel_q, pend_sel_d;
    logic                pend_signed_q, pend_signed_d;
    logic [DATA_W-1:0]   pend_alu_q, pend_alu_d;

    logic                accept;
    logic [7:0]          lane_byte;
    logic [DATA_W-1:0]   load_data;

    assign in_ready = (state_q != WAIT_MEM) && !reset;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        lane_byte = 8'h00;
        case (pend_sel_q)
            2'd0:    lane_byte = mem_rdata[DATA_W-1  -: 8];
            2'd1:    lane_byte = mem_rdata[DATA_W-9  -: 8];
            2'd2:    lane_byte = mem_rdata[DATA_W-17 -: 8];
            default: lane_byte = mem_rdata[DATA_W-25 -: 8];
        endcase
    end

    always_comb begin
        load_data = pend_alu_q;
        case (pend_ctrl_q)
            2'b00:   load_data = mem_rdata;
            2'b01:   load_data = {{(DATA_W-8){pend_signed_q & lane_byte[7]}}, lane_byte};
            default: load_data = pend_alu_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        we_d          = we_q;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        pend_rd_d     = pend_rd_q;
        pend_we_d     = pend_we_q;
        pend_ctrl_d   = pend_ctrl_q;
        pend_sel_d    = pend_sel_q;
        pend_signed_d = pend_signed_q;
        pend_alu_d    = pend_alu_q;

        case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                we_d    = 1'b0;
                if (accept) begin
                    if (in_mem_read) begin
                        state_d       = WAIT_MEM;
                        cnt_d         = '0;
                        pend_rd_d     = in_rd;
                        pend_we_d     = in_reg_we;
                        pend_ctrl_d   = in_wdata_ctrl;
                        pend_sel_d    = in_byte_sel;
                        pend_signed_d = in_byte_signed;
                        pend_alu_d    = in_alu_result;
                    end else if (in_wdata_ctrl[1]) begin
                        state_d    = WRITE;
                        we_d       = in_reg_we && (in_rd != '0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = in_wdata_ctrl[0] ? in_alu_result : in_imm;
                    end else begin
                        // Memory select without a read: retire as a no-op and flag it.
                        state_d = WRITE;
                        err_d   = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rdata_valid) begin
                    state_d    = WRITE;
                    we_d       = pend_we_q && (pend_rd_q != '0);
                    rf_waddr_d = pend_rd_q;
                    rf_wdata_d = load_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            we_q          <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            pend_rd_q     <= '0;
            pend_we_q     <= 1'b0;
            pend_ctrl_q   <= 2'b00;
            pend_sel_q    <= 2'b00;
            pend_signed_q <= 1'b0;
            pend_alu_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            we_q          <= we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            pend_rd_q     <= pend_rd_d;
            pend_we_q     <= pend_we_d;
            pend_ctrl_q   <= pend_ctrl_d;
            pend_sel_q    <= pend_sel_d;
            pend_signed_q <= pend_signed_d;
            pend_alu_q    <= pend_alu_d;
        end
    end

    // A flush during the write cycle cancels the write immediately.
    assign rf_we    = (state_q == WRITE) && we_q && !flush;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign err      = err_q;

endmodule
